// File: rtl/nic_input_arbiter_if.sv
// ---------------------------------------------------------------------------
// nic_input_arbiter_if
//
// One AXI4-Stream link: data, byte strobes, sideband, valid/ready handshake
// and end-of-packet marker.
//
// Parameters:
//   DATA_WIDTH  - tdata width in bits (tstrb is DATA_WIDTH/8 bits)
//   TUSER_WIDTH - tuser width in bits
//
// Signals:
//   tdata  [DATA_WIDTH-1:0]    payload
//   tstrb  [DATA_WIDTH/8-1:0]  byte strobes
//   tuser  [TUSER_WIDTH-1:0]   sideband
//   tvalid                     source has a beat
//   tready                     sink accepts the beat
//   tlast                      last beat of a packet
//
// Modports:
//   master - drives the stream (tready is the input)
//   slave  - receives the stream (tready is the output)
// ---------------------------------------------------------------------------
interface nic_input_arbiter_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 128
) ();

    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (
        output tdata,
        output tstrb,
        output tuser,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tstrb,
        input  tuser,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/nic_input_arbiter.sv
// ---------------------------------------------------------------------------
// nic_input_arbiter
//
// Packet-granular round-robin arbiter merging four AXI4-Stream ingress ports
// into one stream. A grant is held from the first beat of a packet until its
// tlast beat is accepted, so packets are never interleaved. tdata, tstrb,
// tuser and tlast pass through unmodified.
//
// Ports:
//   axi_aclk    in   sole clock
//   axi_resetn  in   asynchronous active-low reset
//   s_axis_0..3 slave modport  ingress streams
//   m_axis      master modport merged egress stream
//
// Build option:
//   NIC_INPUT_ARBITER_OUT_REG_EN - when defined, a 2-entry skid buffer sits
//   on the master side so every master output comes from a flop and the
//   granted port's tready is "buffer not full". When undefined, master
//   outputs and the granted tready are combinational pass-through.
//
// Slave and master data/tuser widths are expected to be equal.
// ---------------------------------------------------------------------------
module nic_input_arbiter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                axi_aclk,
    input  logic                axi_resetn,
    nic_input_arbiter_if.slave  s_axis_0,
    nic_input_arbiter_if.slave  s_axis_1,
    nic_input_arbiter_if.slave  s_axis_2,
    nic_input_arbiter_if.slave  s_axis_3,
    nic_input_arbiter_if.master m_axis
);

    // A beat is carried internally as {tlast, tuser, tstrb, tdata}.
    localparam int SBW = C_S_AXIS_DATA_WIDTH + C_S_AXIS_DATA_WIDTH / 8 + C_S_AXIS_TUSER_WIDTH + 1;
    localparam int MBW = C_M_AXIS_DATA_WIDTH + C_M_AXIS_DATA_WIDTH / 8 + C_M_AXIS_TUSER_WIDTH + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;

    logic [SBW-1:0] s_beat_s [4];
    logic [3:0]     s_tvalid_s;
    logic [3:0]     s_tready_s;

    logic [3:0]     rot_valid_s;
    logic [1:0]     pick_off_s;
    logic           pick_found_s;
    logic [1:0]     pick_port_s;

    logic [SBW-1:0] sel_beat_s;
    logic           sel_valid_s;
    logic           sel_last_s;
    logic           xfer_s;
    logic           up_ready_s;
    logic           accept_s;
    logic           beat_done_s;

    logic [MBW-1:0] m_beat_s;
    logic           m_valid_s;

    assign s_beat_s[0] = {s_axis_0.tlast, s_axis_0.tuser, s_axis_0.tstrb, s_axis_0.tdata};
    assign s_beat_s[1] = {s_axis_1.tlast, s_axis_1.tuser, s_axis_1.tstrb, s_axis_1.tdata};
    assign s_beat_s[2] = {s_axis_2.tlast, s_axis_2.tuser, s_axis_2.tstrb, s_axis_2.tdata};
    assign s_beat_s[3] = {s_axis_3.tlast, s_axis_3.tuser, s_axis_3.tstrb, s_axis_3.tdata};
    assign s_tvalid_s  = {s_axis_3.tvalid, s_axis_2.tvalid, s_axis_1.tvalid, s_axis_0.tvalid};

    assign s_axis_0.tready = s_tready_s[0];
    assign s_axis_1.tready = s_tready_s[1];
    assign s_axis_2.tready = s_tready_s[2];
    assign s_axis_3.tready = s_tready_s[3];

    assign xfer_s      = (state_q == ST_XFER);
    assign sel_beat_s  = s_beat_s[grant_q];
    assign sel_valid_s = s_tvalid_s[grant_q];
    assign sel_last_s  = sel_beat_s[SBW-1];

    // Slave-side handshake on the granted port; its tlast ends the grant.
    assign accept_s    = xfer_s & sel_valid_s & up_ready_s;
    assign beat_done_s = accept_s & sel_last_s;

    // Rotate valids so bit j is port (rr_ptr + j) mod 4; the lowest set bit wins.
    always_comb begin
        case (rr_ptr_q)
            2'd0:    rot_valid_s = s_tvalid_s;
            2'd1:    rot_valid_s = {s_tvalid_s[0],   s_tvalid_s[3:1]};
            2'd2:    rot_valid_s = {s_tvalid_s[1:0], s_tvalid_s[3:2]};
            2'd3:    rot_valid_s = {s_tvalid_s[2:0], s_tvalid_s[3]};
            default: rot_valid_s = s_tvalid_s;
        endcase
    end

    // Priority-encode the rotated request vector into an offset from rr_ptr.
    always_comb begin
        pick_found_s = 1'b1;
        pick_off_s   = 2'd0;
        casez (rot_valid_s)
            4'b???1: pick_off_s = 2'd0;
            4'b??10: pick_off_s = 2'd1;
            4'b?100: pick_off_s = 2'd2;
            4'b1000: pick_off_s = 2'd3;
            default: begin
                pick_found_s = 1'b0;
                pick_off_s   = 2'd0;
            end
        endcase
    end

    assign pick_port_s = rr_ptr_q + pick_off_s;

    // Arbitration FSM next state: grab a port in IDLE, release on its tlast.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_d = ST_XFER;
                    grant_d = pick_port_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (beat_done_s) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = grant_q + 2'd1;
                end else begin
                    state_d = ST_XFER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Arbitration FSM state register.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q  <= ST_IDLE;
            grant_q  <= 2'd0;
            rr_ptr_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Only the granted port sees a ready, and only while transferring.
    always_comb begin
        s_tready_s = 4'b0000;
        if (xfer_s) begin
            s_tready_s[grant_q] = up_ready_s;
        end else begin
            s_tready_s = 4'b0000;
        end
    end

`ifdef NIC_INPUT_ARBITER_OUT_REG_EN

    // Skid buffer: out_* drives the master port, skid_* catches the one beat
    // that can arrive in the cycle the master stalls.
    logic [MBW-1:0] out_beat_q, out_beat_d;
    logic           out_valid_q, out_valid_d;
    logic [MBW-1:0] skid_beat_q, skid_beat_d;
    logic           skid_valid_q, skid_valid_d;
    logic           out_pop_s;

    assign up_ready_s = ~skid_valid_q;
    assign out_pop_s  = out_valid_q & m_axis.tready;

    // Skid buffer next state; accept_s implies the skid entry is empty.
    always_comb begin
        out_beat_d   = out_beat_q;
        out_valid_d  = out_valid_q;
        skid_beat_d  = skid_beat_q;
        skid_valid_d = skid_valid_q;
        if (accept_s) begin
            if (!out_valid_q || out_pop_s) begin
                out_beat_d  = sel_beat_s;
                out_valid_d = 1'b1;
            end else begin
                skid_beat_d  = sel_beat_s;
                skid_valid_d = 1'b1;
            end
        end else if (out_pop_s) begin
            if (skid_valid_q) begin
                out_beat_d   = skid_beat_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Skid buffer registers.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            out_beat_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_beat_q  <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_beat_q   <= out_beat_d;
            out_valid_q  <= out_valid_d;
            skid_beat_q  <= skid_beat_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign m_beat_s  = out_beat_q;
    assign m_valid_s = out_valid_q;

`else

    assign up_ready_s = m_axis.tready;
    assign m_valid_s  = xfer_s & sel_valid_s;

    // Pass-through from the granted port; forced to zero outside a transfer.
    always_comb begin
        if (xfer_s) begin
            m_beat_s = sel_beat_s;
        end else begin
            m_beat_s = '0;
        end
    end

`endif

    assign {m_axis.tlast, m_axis.tuser, m_axis.tstrb, m_axis.tdata} = m_beat_s;
    assign m_axis.tvalid = m_valid_s;

endmodule

// File: tb/tb_nic_input_arbiter.sv
module tb_nic_input_arbiter;

`ifdef NIC_INPUT_ARBITER_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  strb;
        logic [127:0] user;
        logic         last;
        logic         first;
        logic [3:0]   gap;
        logic [1:0]   port;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]   s_tvalid;
    logic [3:0]   s_tlast;
    logic [255:0] s_tdata [4];
    logic [31:0]  s_tstrb [4];
    logic [127:0] s_tuser [4];
    logic [3:0]   s_tready;
    logic         m_tready;

    nic_input_arbiter_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) s_if0 ();
    nic_input_arbiter_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) s_if1 ();
    nic_input_arbiter_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) s_if2 ();
    nic_input_arbiter_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) s_if3 ();
    nic_input_arbiter_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) m_if ();

    assign s_if0.tdata = s_tdata[0]; assign s_if0.tstrb = s_tstrb[0]; assign s_if0.tuser = s_tuser[0];
    assign s_if0.tvalid = s_tvalid[0]; assign s_if0.tlast = s_tlast[0]; assign s_tready[0] = s_if0.tready;
    assign s_if1.tdata = s_tdata[1]; assign s_if1.tstrb = s_tstrb[1]; assign s_if1.tuser = s_tuser[1];
    assign s_if1.tvalid = s_tvalid[1]; assign s_if1.tlast = s_tlast[1]; assign s_tready[1] = s_if1.tready;
    assign s_if2.tdata = s_tdata[2]; assign s_if2.tstrb = s_tstrb[2]; assign s_if2.tuser = s_tuser[2];
    assign s_if2.tvalid = s_tvalid[2]; assign s_if2.tlast = s_tlast[2]; assign s_tready[2] = s_if2.tready;
    assign s_if3.tdata = s_tdata[3]; assign s_if3.tstrb = s_tstrb[3]; assign s_if3.tuser = s_tuser[3];
    assign s_if3.tvalid = s_tvalid[3]; assign s_if3.tlast = s_tlast[3]; assign s_tready[3] = s_if3.tready;
    assign m_if.tready = m_tready;

    nic_input_arbiter dut (
        .axi_aclk   (clk),
        .axi_resetn (rst_n),
        .s_axis_0   (s_if0),
        .s_axis_1   (s_if1),
        .s_axis_2   (s_if2),
        .s_axis_3   (s_if3),
        .m_axis     (m_if)
    );

    // Source queues, expected streams and bookkeeping.
    beat_t        src_q [4][$];
    beat_t        exp_m [$];
    logic [1:0]   exp_s [$];
    bit           rdy_pat [$];
    int           gap_cnt [4];
    int           beats_out [4];
    int           model_ptr;
    int           rdy_pct;
    int           cyc;
    int           first_valid_cyc;
    int           last_m_cyc;
    int           first_port;
    bit           prev_stall;
    logic [416:0] prev_obs;
    int           n_vec;
    int           n_bad;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [416:0] pack(input beat_t b);
        return {b.last, b.user, b.strb, b.data};
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic bit busy();
        bit b;
        b = (exp_m.size() > 0);
        for (int p = 0; p < 4; p++) if (src_q[p].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic load_pkt(input int p, input int n, input logic [255:0] base,
                            input int gap_idx, input int gap_len, input bit rnd_gap);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data  = (base != 256'd0) ? base + 256'(i) : rnd256();
            b.strb  = $urandom;
            b.user  = rnd128();
            b.last  = (i == n - 1);
            b.first = (i == 0);
            if (i == gap_idx) b.gap = 4'(gap_len);
            else if (rnd_gap && i != n - 1 && $urandom_range(3) == 0) b.gap = 4'($urandom_range(1, 3));
            else b.gap = 4'd0;
            b.port  = 2'(p);
            src_q[p].push_back(b);
        end
    endtask

    // Reference: whole packets served round-robin over ports that have one.
    task automatic build_model();
        beat_t cp [4][$];
        beat_t b;
        int    p;
        for (int i = 0; i < 4; i++) cp[i] = src_q[i];
        forever begin
            p = -1;
            for (int k = 0; k < 4; k++)
                if (p < 0 && cp[(model_ptr + k) % 4].size() > 0) p = (model_ptr + k) % 4;
            if (p < 0) break;
            do begin
                b = cp[p].pop_front();
                exp_m.push_back(b);
                exp_s.push_back(2'(p));
            end while (!b.last);
            model_ptr = (p + 1) % 4;
        end
    endtask

    task automatic drive_src();
        for (int p = 0; p < 4; p++) begin
            if (src_q[p].size() > 0 && gap_cnt[p] == 0) begin
                s_tvalid[p] = 1'b1;
                s_tdata[p]  = src_q[p][0].data;
                s_tstrb[p]  = src_q[p][0].strb;
                s_tuser[p]  = src_q[p][0].user;
                s_tlast[p]  = src_q[p][0].last;
            end else begin
                s_tvalid[p] = 1'b0;
                s_tdata[p]  = 256'd0;
                s_tstrb[p]  = 32'd0;
                s_tuser[p]  = 128'd0;
                s_tlast[p]  = 1'b0;
            end
        end
    endtask

    task automatic drive_rdy();
        if (rdy_pat.size() > 0) m_tready = rdy_pat.pop_front();
        else m_tready = (int'($urandom_range(99)) < rdy_pct);
    endtask

    task automatic tick();
        bit           acc [4];
        logic [416:0] obs;
        beat_t        e;
        beat_t        b;
        @(negedge clk);
        cyc++;
        obs = {m_if.tlast, m_if.tuser, m_if.tstrb, m_if.tdata};
        if (prev_stall) begin
            chk("stall_valid", 512'(m_if.tvalid), 512'(1));
            chk("stall_beat", 512'(obs), 512'(prev_obs));
        end
        for (int p = 0; p < 4; p++) begin
            acc[p] = 1'b0;
            if (s_tready[p] !== 1'b0) begin
                chk("ready_owner", 512'(p), (exp_s.size() > 0) ? 512'(exp_s[0]) : 512'(4));
                if (s_tvalid[p]) begin
                    acc[p] = 1'b1;
                    if (exp_s.size() > 0) void'(exp_s.pop_front());
                end
            end
        end
        if (m_if.tvalid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (m_if.tvalid !== 1'b0 && m_tready) begin
            if (exp_m.size() == 0) begin
                chk("extra_beat", 512'(m_if.tvalid), 512'(0));
            end else begin
                e = exp_m.pop_front();
                chk("m_beat", 512'(obs), 512'(pack(e)));
                beats_out[e.port]++;
                if (first_port < 0) first_port = int'(e.port);
                last_m_cyc = cyc;
            end
        end
        prev_stall = (m_if.tvalid === 1'b1) && !m_tready;
        prev_obs   = obs;
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) begin
            if (acc[p]) begin
                b = src_q[p].pop_front();
                gap_cnt[p] = (src_q[p].size() > 0 && !src_q[p][0].first) ? int'(b.gap) : 0;
            end else if (gap_cnt[p] > 0) begin
                gap_cnt[p]--;
            end
        end
        drive_src();
        drive_rdy();
    endtask

    task automatic start_phase();
        cyc             = 0;
        first_valid_cyc = -1;
        last_m_cyc      = -1;
        first_port      = -1;
        for (int p = 0; p < 4; p++) beats_out[p] = 0;
        build_model();
        drive_src();
    endtask

    task automatic run_phase(input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", 512'(busy()), 512'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_bad = 0; model_ptr = 0; rdy_pct = 100; prev_stall = 1'b0; prev_obs = '0;
        for (int p = 0; p < 4; p++) gap_cnt[p] = 0;
        rst_n = 1'b0;
        drive_src();
        drive_rdy();
        #2;
        chk("rst_tvalid", 512'(m_if.tvalid), 512'(0));
        chk("rst_tlast", 512'(m_if.tlast), 512'(0));
        chk("rst_tready", 512'(s_tready), 512'(0));
`ifdef NIC_INPUT_ARBITER_OUT_REG_EN
        chk("rst_tdata", 512'(m_if.tdata), 512'(0));
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Simultaneous request from reset: port 0 first, one bubble, port 1.
        load_pkt(0, 2, 256'd0, -1, 0, 1'b0);
        load_pkt(1, 2, 256'd0, -1, 0, 1'b0);
        start_phase();
        run_phase(200);
        chk("simul_first_cyc", 512'(first_valid_cyc), 512'(LAT));
        chk("simul_last_cyc", 512'(last_m_cyc), 512'(LAT + 4));
        tick();

        // Single 3-beat packet on port 2.
        load_pkt(2, 3, 256'hA0, -1, 0, 1'b0);
        start_phase();
        run_phase(200);
        chk("single_first_cyc", 512'(first_valid_cyc), 512'(LAT));
        tick();

        // After port 2, port 3 has priority over port 0.
        load_pkt(0, 1, 256'd0, -1, 0, 1'b0);
        load_pkt(3, 1, 256'd0, -1, 0, 1'b0);
        start_phase();
        run_phase(200);
        chk("rr_after_port2", 512'(first_port), 512'(3));
        tick();

        // Fairness: 16 packets of 4 beats on every port.
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 16; k++) load_pkt(p, 4, 256'd0, -1, 0, 1'b0);
        start_phase();
        run_phase(2000);
        for (int p = 0; p < 4; p++) chk("fair_beats", 512'(beats_out[p]), 512'(64));
        tick();

        // Backpressure mid-packet.
        load_pkt(0, 4, 256'd0, -1, 0, 1'b0);
        rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b1);
        rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b1);
        start_phase();
        run_phase(200);
        tick();

        // Port 1 pauses 5 cycles mid-packet while port 3 waits.
        load_pkt(1, 4, 256'd0, 1, 5, 1'b0);
        load_pkt(3, 2, 256'd0, -1, 0, 1'b0);
        start_phase();
        run_phase(200);
        chk("gap_first_port", 512'(first_port), 512'(1));
        tick();

        // Reset in the middle of a packet.
        load_pkt(1, 6, 256'd0, -1, 0, 1'b0);
        load_pkt(2, 3, 256'd0, -1, 0, 1'b0);
        start_phase();
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", 512'(m_if.tvalid), 512'(0));
        chk("arst_tready", 512'(s_tready), 512'(0));
        for (int p = 0; p < 4; p++) begin
            src_q[p].delete();
            gap_cnt[p] = 0;
        end
        exp_m.delete(); exp_s.delete(); rdy_pat.delete();
        prev_stall = 1'b0; model_ptr = 0;
        drive_src();
        repeat (2) tick();
        rst_n = 1'b1;
        for (int p = 3; p >= 0; p--) load_pkt(p, 1, 256'd0, -1, 0, 1'b0);
        start_phase();
        run_phase(200);
        chk("post_rst_first_port", 512'(first_port), 512'(0));
        tick();

        // Randomized traffic with gaps and backpressure.
        for (int r = 0; r < 20; r++) begin
            rdy_pct = int'($urandom_range(40, 100));
            for (int p = 0; p < 4; p++)
                for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                    load_pkt(p, int'($urandom_range(1, 5)), 256'd0, -1, 0, 1'b1);
            start_phase();
            run_phase(1500);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
